// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller.
//   - operand / nibble / product widths
//   - controller state encoding
//   - partial-product shift amount per state
package mul_seq_pkg;

    localparam int W_OP   = 8;
    localparam int W_NIB  = 4;
    localparam int W_PROD = 16;
    localparam int W_PP   = 2 * W_NIB;

    localparam logic [3:0] SHIFT_P0 = 4'd0;
    localparam logic [3:0] SHIFT_P1 = 4'd4;
    localparam logic [3:0] SHIFT_P2 = 4'd4;
    localparam logic [3:0] SHIFT_P3 = 4'd8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        DONE = 3'd5
    } state_t;

    // Left shift applied to the extended partial product in each state.
    function automatic logic [3:0] shift_of(input state_t s);
        logic [3:0] sh;
        sh = 4'd0;
        case (s)
            P0:      sh = SHIFT_P0;
            P1:      sh = SHIFT_P1;
            P2:      sh = SHIFT_P2;
            P3:      sh = SHIFT_P3;
            default: sh = 4'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul4x4_core.sv
// Combinational 4x4 multiplier with independent signedness per operand.
// Ports:
//   a, b          in   4-bit operands
//   a_signed      in   1 = a is two's complement, 0 = unsigned
//   b_signed      in   1 = b is two's complement, 0 = unsigned
//   product       out  8-bit product (two's complement when either flag set)
module mul4x4_core
    import mul_seq_pkg::*;
(
    input  logic [W_NIB-1:0] a,
    input  logic [W_NIB-1:0] b,
    input  logic             a_signed,
    input  logic             b_signed,
    output logic [W_PP-1:0]  product
);

    logic [W_PP-1:0] a_ext;
    logic [W_PP-1:0] b_ext;

    // Extending both operands to the full product width makes the low
    // W_PP bits of a plain multiply correct for every sign combination;
    // the largest magnitudes (15*15, -8*15) still fit in 8 bits.
    assign a_ext   = {{(W_PP-W_NIB){a_signed & a[W_NIB-1]}}, a};
    assign b_ext   = {{(W_PP-W_NIB){b_signed & b[W_NIB-1]}}, b};
    assign product = a_ext * b_ext;

endmodule

// File: rtl/mul8x8_seq_ctrl.sv
// Sequential 8x8 signed/unsigned multiplier built around one shared 4x4
// core. Four partial-product cycles (P0..P3) are accumulated into a 16-bit
// sum; the result register updates only at the end of P3.
//
// state | meaning
// IDLE  | waiting for start
// P0    | aL*bL, unsigned, <<0
// P1    | aH*bL, aH signed in signed mode, <<4
// P2    | aL*bH, bH signed in signed mode, <<4
// P3    | aH*bH, both signed in signed mode, <<8, load product
// DONE  | one-cycle done pulse; start here chains straight into P0
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   request, honoured only in IDLE or DONE
//   signed_mode  in   1 = two's complement operands, 0 = unsigned
//   a, b         in   8-bit operands, latched on accepted start
//   busy         out  high in P0..P3
//   done         out  high in DONE
//   product      out  16-bit result register
module mul8x8_seq_ctrl
    import mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [W_OP-1:0]   a,
    input  logic [W_OP-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [W_PROD-1:0] product
);

    state_t              state;
    state_t              state_nxt;
    logic [W_OP-1:0]     a_lat;
    logic [W_OP-1:0]     b_lat;
    logic                mode_lat;
    logic [W_PROD-1:0]   acc;
    logic [W_PROD-1:0]   product_r;

    logic [W_NIB-1:0]    core_a;
    logic [W_NIB-1:0]    core_b;
    logic                core_a_signed;
    logic                core_b_signed;
    logic [W_PP-1:0]     core_pp;

    logic                accept;
    logic                ext_sign;
    logic [3:0]          shift;
    logic [W_PROD-1:0]   pp_ext;
    logic [W_PROD-1:0]   term;
    logic [W_PROD-1:0]   acc_sum;

    mul4x4_core u_core (
        .a        (core_a),
        .b        (core_b),
        .a_signed (core_a_signed),
        .b_signed (core_b_signed),
        .product  (core_pp)
    );

    always_comb begin
        state_nxt     = state;
        core_a        = '0;
        core_b        = '0;
        core_a_signed = 1'b0;
        core_b_signed = 1'b0;
        ext_sign      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = P0;
            end
            P0: begin
                core_a    = a_lat[W_NIB-1:0];
                core_b    = b_lat[W_NIB-1:0];
                state_nxt = P1;
            end
            P1: begin
                core_a        = a_lat[W_OP-1:W_NIB];
                core_b        = b_lat[W_NIB-1:0];
                core_a_signed = mode_lat;
                ext_sign      = mode_lat;
                state_nxt     = P2;
            end
            P2: begin
                core_a        = a_lat[W_NIB-1:0];
                core_b        = b_lat[W_OP-1:W_NIB];
                core_b_signed = mode_lat;
                ext_sign      = mode_lat;
                state_nxt     = P3;
            end
            P3: begin
                core_a        = a_lat[W_OP-1:W_NIB];
                core_b        = b_lat[W_OP-1:W_NIB];
                core_a_signed = mode_lat;
                core_b_signed = mode_lat;
                ext_sign      = mode_lat;
                state_nxt     = DONE;
            end
            DONE: begin
                state_nxt = start ? P0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // P0 is always a non-negative product, so it is zero-extended even in
    // signed mode; the other terms carry the sign of their signed nibble(s).
    assign shift   = shift_of(state);
    assign pp_ext  = ext_sign ? {{(W_PROD-W_PP){core_pp[W_PP-1]}}, core_pp}
                              : {{(W_PROD-W_PP){1'b0}}, core_pp};
    assign term    = pp_ext << shift;
    assign acc_sum = acc + term;

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign busy    = (state == P0) || (state == P1) || (state == P2) || (state == P3);
    assign done    = (state == DONE);
    assign product = product_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_lat     <= '0;
            b_lat     <= '0;
            mode_lat  <= 1'b0;
            acc       <= '0;
            product_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_lat    <= a;
                b_lat    <= b;
                mode_lat <= signed_mode;
                acc      <= '0;
            end else if (busy) begin
                acc <= acc_sum;
            end
            if (state == P3) begin
                product_r <= acc_sum;
            end
        end
    end

endmodule
